// File: rtl/seg7_scan_capture.sv
//==============================================================================
// Module      : seg7_scan_capture
// Description : Watches a multiplexed 4-digit active-low 7-segment bus and
//               reconstructs the 16-bit hex value being displayed. A digit is
//               committed once its anode/segment pattern has been stable for
//               STABLE_CYCLES synchronized samples.
//               Optional macro SEG7_CAPTURE_DP_EN adds decimal-point capture
//               (dp_out) and includes dp_n in the stability compare.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seg7_scan_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an_n,
  input  logic [6:0]  seg_n,
  input  logic        dp_n,
  output logic [15:0] hex_out,
  output logic [3:0]  digit_valid,
  output logic        frame_strobe,
  output logic        code_err
`ifdef SEG7_CAPTURE_DP_EN
  ,
  output logic [3:0]  dp_out
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Synchronizer chains; reset to all-ones so the bus looks idle.
  logic [SYNC_STAGES-1:0][3:0] an_sync_q;
  logic [SYNC_STAGES-1:0][6:0] seg_sync_q;
  logic [3:0] an_s;
  logic [6:0] seg_s;

`ifdef SEG7_CAPTURE_DP_EN
  localparam int CMP_W = 12;
  logic [SYNC_STAGES-1:0] dp_sync_q;
  logic dp_s;
  logic [3:0] dp_q, dp_d;
`else
  localparam int CMP_W = 11;
  logic dp_unused;
  assign dp_unused = dp_n;
`endif

  // Shift the raw bus through the synchronizer stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_sync_q  <= '1;
      seg_sync_q <= '1;
`ifdef SEG7_CAPTURE_DP_EN
      dp_sync_q  <= '1;
`endif
    end else begin
      an_sync_q  <= {an_sync_q[SYNC_STAGES-2:0], an_n};
      seg_sync_q <= {seg_sync_q[SYNC_STAGES-2:0], seg_n};
`ifdef SEG7_CAPTURE_DP_EN
      dp_sync_q  <= {dp_sync_q[SYNC_STAGES-2:0], dp_n};
`endif
    end
  end

  assign an_s  = an_sync_q[SYNC_STAGES-1];
  assign seg_s = seg_sync_q[SYNC_STAGES-1];

  logic [CMP_W-1:0] cmp_s, prev_q;
`ifdef SEG7_CAPTURE_DP_EN
  assign dp_s  = dp_sync_q[SYNC_STAGES-1];
  assign cmp_s = {an_s, seg_s, dp_s};
`else
  assign cmp_s = {an_s, seg_s};
`endif

  // Previous-cycle snapshot used for the stability compare.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= '1;
    else     prev_q <= cmp_s;
  end

  logic       same;
  logic [3:0] an_act;
  logic       sel_valid;
  logic [1:0] sel_idx;
  logic [3:0] sel_oh;

  assign same      = (cmp_s == prev_q);
  assign an_act    = ~an_s;
  // Exactly one anode low: non-zero and a power of two.
  assign sel_valid = (an_act != 4'd0) && ((an_act & (an_act - 4'd1)) == 4'd0);
  assign sel_oh    = 4'b0001 << sel_idx;

  // Index of the selected digit (meaningful only when sel_valid).
  always_comb begin
    sel_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (an_act[i]) sel_idx = 2'(i);
    end
  end

  // Segment pattern to {glyph_ok, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 5'h10;
      7'b1001111: decode = 5'h11;
      7'b0010010: decode = 5'h12;
      7'b0000110: decode = 5'h13;
      7'b1001100: decode = 5'h14;
      7'b0100100: decode = 5'h15;
      7'b0100000: decode = 5'h16;
      7'b0001111: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0000100: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b1100000: decode = 5'h1B;
      7'b0110001: decode = 5'h1C;
      7'b1000010: decode = 5'h1D;
      7'b0110000: decode = 5'h1E;
      7'b0111000: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // FSM state and dwell counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: count identical samples, restart on any change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          state_d = S_DWELL;
          cnt_d   = 8'd1;
        end
      end
      S_DWELL: begin
        if (!same) begin
          if (sel_valid) cnt_d = 8'd1;
          else           state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) state_d = S_HELD;
        end
      end
      S_HELD: begin
        if (!same) begin
          if (sel_valid) begin
            state_d = S_DWELL;
            cnt_d   = 8'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic        commit;
  logic [4:0]  dec;
  logic [15:0] hex_q, hex_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  seen_q, seen_d;
  logic        frame_q, frame_d;
  logic        err_q, err_d;

  assign commit = (state_q == S_DWELL) && same && (cnt_q == CNT_LAST);
  assign dec    = decode(seg_s);

  // Output logic: apply a commit to the captured value and frame tracking.
  always_comb begin
    hex_d   = hex_q;
    valid_d = valid_q;
    seen_d  = seen_q;
    frame_d = 1'b0;
    err_d   = 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
    dp_d    = dp_q;
`endif
    if (commit) begin
      seen_d = seen_q | sel_oh;
      if (dec[4]) begin
        hex_d[{sel_idx, 2'b00} +: 4] = dec[3:0];
        valid_d[sel_idx]             = 1'b1;
      end else begin
        valid_d[sel_idx] = 1'b0;
        if (seg_s != SEG_BLANK) err_d = 1'b1;
      end
      if (seen_d == 4'hF) begin
        frame_d = 1'b1;
        seen_d  = 4'h0;
      end
`ifdef SEG7_CAPTURE_DP_EN
      dp_d[sel_idx] = ~dp_s;
`endif
    end
  end

  // Captured value, flags and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_q   <= 16'h0000;
      valid_q <= 4'h0;
      seen_q  <= 4'h0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
      dp_q    <= 4'h0;
`endif
    end else begin
      hex_q   <= hex_d;
      valid_q <= valid_d;
      seen_q  <= seen_d;
      frame_q <= frame_d;
      err_q   <= err_d;
`ifdef SEG7_CAPTURE_DP_EN
      dp_q    <= dp_d;
`endif
    end
  end

  assign hex_out      = hex_q;
  assign digit_valid  = valid_q;
  assign frame_strobe = frame_q;
  assign code_err     = err_q;
`ifdef SEG7_CAPTURE_DP_EN
  assign dp_out       = dp_q;
`endif

endmodule

`default_nettype wire
